// File: rtl/program_word_loader_pkg.sv
// Shared constants and state encoding for the program word loader.
package program_word_loader_pkg;

    localparam int DEF_IA_W = 16;            // program memory address width
    localparam int DEF_ID_W = 24;            // program word width (multiple of 8)
    localparam int DEF_NB   = DEF_ID_W / 8;  // bytes per program word

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_CHECK   = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

endpackage

// File: rtl/program_word_loader_if.sv
// Bus bundle between a byte source / controller (master) and the loader (slave).
// Handshake: a byte moves on a rising edge only when RX_V=1 and RX_RDY=1 in the
// same cycle; RX_D is don't-care otherwise. RX_RDY depends on loader state only,
// never on RX_V, so the source may hold RX_V high while RX_RDY is low.
interface program_word_loader_if #(
    parameter int IA_W = program_word_loader_pkg::DEF_IA_W,
    parameter int ID_W = program_word_loader_pkg::DEF_ID_W
);
    import program_word_loader_pkg::*;

    logic            START;
    logic            ABORT;
    logic [IA_W-1:0] BASE_A;
    logic [IA_W:0]   LEN;
    logic [7:0]      RX_D;
    logic            RX_V;
    logic            RX_RDY;
    logic [IA_W-1:0] A;
    logic            WE;
    logic [ID_W-1:0] DI;
    logic            BUSY;
    logic            DONE;
    logic            ERR;
    state_t          dbg_state;

    modport master (
        output START, ABORT, BASE_A, LEN, RX_D, RX_V,
        input  RX_RDY, A, WE, DI, BUSY, DONE, ERR, dbg_state
    );

    modport slave (
        input  START, ABORT, BASE_A, LEN, RX_D, RX_V,
        output RX_RDY, A, WE, DI, BUSY, DONE, ERR, dbg_state
    );

endinterface

// File: rtl/program_word_loader_byte_packer.sv
// Assembles incoming bytes MSB-first into a program word and keeps a running
// XOR checksum of every shifted byte.
module loader_byte_packer #(
    parameter int ID_W = program_word_loader_pkg::DEF_ID_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            shift_i,
    input  logic [7:0]      byte_i,
    output logic [ID_W-1:0] word_o,
    output logic [7:0]      chk_o,
    output logic            word_done_o
);
    localparam int NB = ID_W / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    logic [ID_W-1:0] word_q, word_d;
    logic [7:0]      chk_q, chk_d;
    logic [IW-1:0]   idx_q, idx_d;

    assign word_done_o = shift_i && (idx_q == IW'(NB - 1));
    assign word_o      = word_q;
    assign chk_o       = chk_q;

    // Next-state: shift the byte in at the LSB end, fold it into the checksum.
    always_comb begin
        word_d = word_q;
        chk_d  = chk_q;
        idx_d  = idx_q;
        if (clr_i) begin
            word_d = '0;
            chk_d  = '0;
            idx_d  = '0;
        end else if (shift_i) begin
            word_d = (word_q << 8) | ID_W'(byte_i);
            chk_d  = chk_q ^ byte_i;
            idx_d  = word_done_o ? '0 : idx_q + IW'(1);
        end
    end

    // Packer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
            chk_q  <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            chk_q  <= chk_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/program_word_loader.sv
// Program word loader: receives a byte stream, writes LEN words starting at
// BASE_A, then verifies a trailing XOR checksum byte.
module program_word_loader #(
    parameter int IA_W = program_word_loader_pkg::DEF_IA_W,
    parameter int ID_W = program_word_loader_pkg::DEF_ID_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    program_word_loader_if.slave  bus
);
    import program_word_loader_pkg::*;

    state_t          state_q, state_d;
    logic [IA_W-1:0] addr_q, addr_d;
    logic [IA_W:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [IA_W-1:0] a_hold_q, a_hold_d;
    logic [ID_W-1:0] di_hold_q, di_hold_d;

    logic            rx_rdy;
    logic            accept;
    logic            start_ok;
    logic            we;
    logic            done;
    logic [ID_W-1:0] word;
    logic [7:0]      chk;
    logic            word_done;

    assign rx_rdy   = (state_q == S_COLLECT) || (state_q == S_CHECK);
    // An aborting cycle never consumes a byte.
    assign accept   = bus.RX_V && rx_rdy && !bus.ABORT;
    assign start_ok = (state_q == S_IDLE) && bus.START;

    loader_byte_packer #(.ID_W(ID_W)) u_packer (
        .clk_i       (CLK),
        .rst_i       (RST),
        .clr_i       (start_ok),
        .shift_i     (accept && (state_q == S_COLLECT)),
        .byte_i      (bus.RX_D),
        .word_o      (word),
        .chk_o       (chk),
        .word_done_o (word_done)
    );

    // Next-state and output decode; abort outside IDLE overrides every state.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        a_hold_d  = a_hold_q;
        di_hold_d = di_hold_q;
        we        = 1'b0;
        done      = 1'b0;
        if ((state_q != S_IDLE) && bus.ABORT) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.START) begin
                        addr_d  = bus.BASE_A;
                        cnt_d   = bus.LEN;
                        err_d   = 1'b0;
                        state_d = (bus.LEN != '0) ? S_COLLECT : S_CHECK;
                    end
                end
                S_COLLECT: begin
                    if (word_done) state_d = S_WRITE;
                end
                S_WRITE: begin
                    we        = 1'b1;
                    a_hold_d  = addr_q;
                    di_hold_d = word;
                    addr_d    = addr_q + IA_W'(1);
                    cnt_d     = cnt_q - (IA_W + 1)'(1);
                    state_d   = (cnt_q == (IA_W + 1)'(1)) ? S_CHECK : S_COLLECT;
                end
                S_CHECK: begin
                    if (accept) begin
                        err_d   = (bus.RX_D != chk);
                        state_d = S_FINISH;
                    end
                end
                S_FINISH: begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, counters and the held write address/data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            a_hold_q  <= '0;
            di_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            a_hold_q  <= a_hold_d;
            di_hold_q <= di_hold_d;
        end
    end

    // A/DI show the live write while WE is high and otherwise hold the last write.
    assign bus.A         = we ? addr_q : a_hold_q;
    assign bus.DI        = we ? word : di_hold_q;
    assign bus.WE        = we;
    assign bus.RX_RDY    = rx_rdy;
    assign bus.BUSY      = (state_q != S_IDLE);
    assign bus.DONE      = done;
    assign bus.ERR       = err_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_program_word_loader.sv
// Self-checking bench for program_word_loader: directed scenarios plus random
// loads checked against a word/checksum model of the load protocol.
module tb_program_word_loader;

    localparam int IA_W = 16;
    localparam int ID_W = 24;
    localparam int NB   = ID_W / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    program_word_loader_if #(.IA_W(IA_W), .ID_W(ID_W)) bus ();

    program_word_loader #(.IA_W(IA_W), .ID_W(ID_W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int wr_cnt   = 0;

    logic [IA_W+ID_W-1:0] exp_q[$];
    logic [7:0]           tx_q[$];
    logic [IA_W+ID_W-1:0] mon_exp;

    // Scoreboard: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.DONE === 1'b1) done_cnt++;
        if (bus.WE === 1'b1) begin
            wr_cnt++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: got A=%h DI=%h, required no write", bus.A, bus.DI);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.A, bus.DI} !== mon_exp)
                    begin
                        n_fail++;
                        $display("FAIL write_data: got A=%h DI=%h, required A=%h DI=%h",
                                 bus.A, bus.DI, mon_exp[IA_W+ID_W-1:ID_W], mon_exp[ID_W-1:0]);
                    end
            end
            n_tests++;
            if (bus.RX_RDY !== 1'b0) begin
                n_fail++;
                $display("FAIL rdy_in_write: got RX_RDY=%b, required 0", bus.RX_RDY);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.START  = 1'b0;
        bus.ABORT  = 1'b0;
        bus.BASE_A = '0;
        bus.LEN    = '0;
        bus.RX_D   = '0;
        bus.RX_V   = 1'b0;
    endtask

    task automatic do_start(input logic [IA_W-1:0] base, input logic [IA_W:0] len, input bit with_abort);
        bus.START  = 1'b1;
        bus.BASE_A = base;
        bus.LEN    = len;
        bus.ABORT  = with_abort;
        tick();
        bus.START  = 1'b0;
        bus.ABORT  = 1'b0;
        bus.BASE_A = IA_W'($urandom);
        bus.LEN    = (IA_W + 1)'($urandom);
        @(negedge clk);
        n_tests++;
        if ({bus.BUSY, bus.ERR, bus.DONE} !== 3'b100) begin
            n_fail++;
            $display("FAIL start_state: got BUSY/ERR/DONE=%b, required 100", {bus.BUSY, bus.ERR, bus.DONE});
        end
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        int budget;
        repeat (gap) begin
            bus.RX_V = 1'b0;
            bus.RX_D = 8'($urandom);
            tick();
        end
        bus.RX_V = 1'b1;
        bus.RX_D = b;
        ok       = 1'b0;
        budget   = 0;
        while (!ok && budget < 200) begin
            @(negedge clk);
            ok = (bus.RX_RDY === 1'b1);
            tick();
            budget++;
        end
        bus.RX_V = 1'b0;
        bus.RX_D = 8'($urandom);
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL send_timeout: got no RX_RDY in %0d cycles, required RX_RDY=1", budget);
        end
    endtask

    task automatic finish_check(input bit exp_err, input int done_before);
        @(negedge clk);
        n_tests++;
        if ({bus.DONE, bus.ERR, bus.BUSY, bus.WE} !== {1'b1, exp_err, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL finish_pulse: got DONE/ERR/BUSY/WE=%b, required %b",
                     {bus.DONE, bus.ERR, bus.BUSY, bus.WE}, {1'b1, exp_err, 1'b1, 1'b0});
        end
        tick();
        @(negedge clk);
        n_tests++;
        if ({bus.DONE, bus.ERR, bus.BUSY} !== {1'b0, exp_err, 1'b0}) begin
            n_fail++;
            $display("FAIL after_finish: got DONE/ERR/BUSY=%b, required %b",
                     {bus.DONE, bus.ERR, bus.BUSY}, {1'b0, exp_err, 1'b0});
        end
        n_tests++;
        if (exp_q.size() != 0 || done_cnt != done_before + 1) begin
            n_fail++;
            $display("FAIL load_totals: got %0d writes missing, %0d done pulses, required 0 and 1",
                     exp_q.size(), done_cnt - done_before);
        end
        tick();
    endtask

    // Runs one load of the bytes in tx_q; busy_at >= 0 pulses a stray START
    // while that byte is being sent.
    task automatic run_load(input logic [IA_W-1:0] base, input int len, input logic [7:0] chk,
                            input int gap_min, input int gap_max, input bit with_abort, input int busy_at);
        logic [7:0]      x;
        logic [ID_W-1:0] w;
        int              d0;
        bit              exp_err;
        x = 8'h00;
        foreach (tx_q[i]) x = x ^ tx_q[i];
        for (int k = 0; k < len; k++) begin
            w = '0;
            for (int j = 0; j < NB; j++) w = {w[ID_W-9:0], tx_q[k*NB+j]};
            exp_q.push_back({base + IA_W'(k), w});
        end
        exp_err = (chk != x);
        d0 = done_cnt;
        do_start(base, (IA_W + 1)'(len), with_abort);
        foreach (tx_q[i]) begin
            if (i == busy_at) begin
                bus.START  = 1'b1;
                bus.BASE_A = IA_W'($urandom);
                bus.LEN    = (IA_W + 1)'($urandom_range(1, 9));
            end
            send_byte(tx_q[i], $urandom_range(gap_max, gap_min));
            bus.START = 1'b0;
        end
        send_byte(chk, $urandom_range(gap_max, gap_min));
        finish_check(exp_err, d0);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.START = 1'b1;
        bus.ABORT = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_tests++;
        if ({bus.A, bus.DI, bus.WE, bus.RX_RDY, bus.BUSY, bus.DONE, bus.ERR} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got A=%h DI=%h WE/RDY/BUSY/DONE/ERR=%b, required all 0",
                     bus.A, bus.DI, {bus.WE, bus.RX_RDY, bus.BUSY, bus.DONE, bus.ERR});
        end
        tick();
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        run_load(16'h0010, 2, 8'h77, 0, 0, 1'b0, -1);
    endtask

    task automatic test_bad_checksum();
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        run_load(16'h0010, 2, 8'h00, 0, 1, 1'b0, -1);
        @(negedge clk);
        n_tests++;
        if ({bus.A, bus.DI, bus.ERR} !== {16'h0011, 24'h445566, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_outputs: got A=%h DI=%h ERR=%b, required A=0011 DI=445566 ERR=1",
                     bus.A, bus.DI, bus.ERR);
        end
        tick();
    endtask

    task automatic test_len_zero();
        int w0;
        w0 = wr_cnt;
        tx_q.delete();
        run_load(16'h1234, 0, 8'h00, 0, 2, 1'b1, -1);
        n_tests++;
        if (wr_cnt !== w0) begin
            n_fail++;
            $display("FAIL len_zero_writes: got %0d writes, required 0", wr_cnt - w0);
        end
    endtask

    task automatic test_wrap();
        tx_q.delete();
        for (int i = 0; i < 2 * NB; i++) tx_q.push_back(8'($urandom));
        run_load(16'hFFFF, 2, tx_q[0] ^ tx_q[1] ^ tx_q[2] ^ tx_q[3] ^ tx_q[4] ^ tx_q[5], 1, 1, 1'b0, -1);
    endtask

    task automatic test_abort_rst();
        int w0;
        int d0;
        w0 = wr_cnt;
        d0 = done_cnt;
        // abort part-way through the first word
        do_start(16'h0100, 17'd3, 1'b0);
        send_byte(8'hA1, 0);
        send_byte(8'hA2, 1);
        bus.ABORT = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.WE !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_collect_we: got WE=%b, required 0", bus.WE);
        end
        tick();
        bus.ABORT = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.BUSY, bus.ERR, bus.DONE} !== 3'b010) begin
            n_fail++;
            $display("FAIL abort_collect_state: got BUSY/ERR/DONE=%b, required 010", {bus.BUSY, bus.ERR, bus.DONE});
        end
        tick();
        // abort in the cycle the word would be written
        do_start(16'h0200, 17'd1, 1'b0);
        send_byte(8'hB1, 0);
        send_byte(8'hB2, 0);
        send_byte(8'hB3, 0);
        bus.ABORT = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.WE !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_write_we: got WE=%b, required 0", bus.WE);
        end
        tick();
        bus.ABORT = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.BUSY, bus.ERR, bus.DONE} !== 3'b010) begin
            n_fail++;
            $display("FAIL abort_write_state: got BUSY/ERR/DONE=%b, required 010", {bus.BUSY, bus.ERR, bus.DONE});
        end
        tick();
        // reset in the middle of a second load
        do_start(16'h0300, 17'd2, 1'b0);
        send_byte(8'hC1, 0);
        send_byte(8'hC2, 0);
        rst = 1'b1;
        bus.RX_V = 1'b1;
        tick();
        @(negedge clk);
        n_tests++;
        if ({bus.A, bus.DI, bus.WE, bus.RX_RDY, bus.BUSY, bus.DONE, bus.ERR} !== '0) begin
            n_fail++;
            $display("FAIL rst_midload: got A=%h DI=%h WE/RDY/BUSY/DONE/ERR=%b, required all 0",
                     bus.A, bus.DI, {bus.WE, bus.RX_RDY, bus.BUSY, bus.DONE, bus.ERR});
        end
        tick();
        rst = 1'b0;
        idle_inputs();
        repeat (3) tick();
        n_tests++;
        if (wr_cnt !== w0 || done_cnt !== d0) begin
            n_fail++;
            $display("FAIL abort_no_activity: got %0d writes %0d done pulses, required 0 and 0",
                     wr_cnt - w0, done_cnt - d0);
        end
    endtask

    task automatic test_start_busy();
        logic [7:0] x;
        tx_q.delete();
        x = 8'h00;
        for (int i = 0; i < 2 * NB; i++) begin
            tx_q.push_back(8'($urandom));
            x = x ^ tx_q[i];
        end
        run_load(16'h0200, 2, x, 0, 1, 1'b0, 1);
    endtask

    task automatic test_random();
        logic [7:0] x;
        int         len;
        for (int n = 0; n < 10; n++) begin
            len = $urandom_range(1, 4);
            tx_q.delete();
            x = 8'h00;
            for (int i = 0; i < len * NB; i++) begin
                tx_q.push_back(8'($urandom));
                x = x ^ tx_q[i];
            end
            if ($urandom_range(0, 1) == 1) x = x ^ 8'($urandom_range(1, 255));
            run_load(IA_W'($urandom), len, x, 0, 2, 1'($urandom_range(0, 1)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_checksum();
        test_len_zero();
        test_wrap();
        test_abort_rst();
        test_start_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/program_word_loader.md
PROGRAM_WORD_LOADER -- requirements
Module: program_word_loader

Interface
REQ-001 Parameter IA_W, default 16, program memory address width.
REQ-002 Parameter ID_W, default 24, program word width; SHALL be a multiple of 8; NB = ID_W/8 bytes per word.
REQ-003 CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 START  input  1  single-cycle request to begin a load; honoured only in IDLE.
REQ-006 ABORT  input  1  terminates any load in progress.
REQ-007 BASE_A  input  IA_W  first word address, sampled with START.
REQ-008 LEN  input  IA_W+1  word count, sampled with START; 0 allowed.
REQ-009 RX_D  input  8  incoming byte.
REQ-010 RX_V  input  1  RX_D valid.
REQ-011 RX_RDY  output  1  loader accepts a byte this cycle.
REQ-012 A  output  IA_W  memory address.
REQ-013 WE  output  1  memory write enable.
REQ-014 DI  output  ID_W  memory write data.
REQ-015 BUSY  output  1  high in any state other than IDLE.
REQ-016 DONE  output  1  one-cycle completion pulse.
REQ-017 ERR  output  1  checksum mismatch or abort flag of the last load.

Function
REQ-018 States: IDLE, COLLECT, WRITE, CHECK, FINISH.
REQ-019 Byte transfer occurs only on a cycle with RX_V=1 and RX_RDY=1; RX_D SHALL be ignored otherwise.
REQ-020 RX_RDY = 1 exactly in COLLECT and CHECK; 0 in IDLE, WRITE, FINISH.
REQ-021 IDLE + START: latch BASE_A into address register, LEN into word counter, clear byte index, checksum (8-bit XOR) and ERR; next state COLLECT if LEN != 0, else CHECK.
REQ-022 START outside IDLE SHALL be ignored.
REQ-023 COLLECT: each accepted byte shifts into the word register MSB-first (first byte becomes DI[ID_W-1:ID_W-8]) and XORs into checksum; on the NB-th byte, next state WRITE.
REQ-024 WRITE lasts exactly one cycle: WE=1, A=address register, DI=assembled word; WE SHALL be 0 in every other state.
REQ-025 Write latency: WE asserted the cycle after the last byte of a word is accepted.
REQ-026 After WRITE: address increments modulo 2^IA_W (wrap FFFF->0000 for IA_W=16, no error), word counter decrements; next state CHECK if counter reaches 0, else COLLECT.
REQ-027 CHECK: one accepted byte compared with running checksum; ERR=1 on mismatch, 0 on match; next state FINISH.
REQ-028 FINISH lasts one cycle: DONE=1, then IDLE; ERR held until next START or RST.
REQ-029 ABORT in any non-IDLE state: next state IDLE, ERR=1, no DONE pulse, WE=0 that cycle even if in WRITE (no partial write); ABORT in IDLE has no effect.
REQ-030 ABORT and START in the same IDLE cycle: START wins.
REQ-031 A and DI hold their last values when WE=0.

Reset
REQ-032 RST=1 overrides START/ABORT and forces, on the next edge: state IDLE, A=0, DI=0, WE=0, RX_RDY=0, BUSY=0, DONE=0, ERR=0, counters/checksum 0.
REQ-033 RST mid-load discards the partial word; no write issued.

Structure
REQ-034 Shared package holds IA_W, ID_W, NB and the state encoding constants.
REQ-035 One sub-module, loader_byte_packer (shift register, byte index, XOR checksum, word-complete flag); FSM and address/word counters stay in the top.

Verification
REQ-036 BASE_A=0x0010, LEN=2, bytes 11 22 33 44 55 66, checksum 0x77 -> WE pulses with A=0x0010/DI=0x112233, A=0x0011/DI=0x445566; DONE one cycle, ERR=0.
REQ-037 Same load with checksum byte 0x00 -> identical writes, DONE pulse, ERR=1.
REQ-038 LEN=0, checksum byte 0x00 -> no WE, DONE after one byte, ERR=0.
REQ-039 BASE_A=0xFFFF, LEN=2, RX_V toggling every other cycle -> writes at 0xFFFF then 0x0000; RX_RDY low during each WRITE cycle.
REQ-040 ABORT after 2 of 3 bytes of first word, then RST mid-second load -> no WE, ERR=1 after abort, all outputs 0 after RST.
REQ-041 START pulsed while BUSY -> ignored; latched BASE_A/LEN unchanged.
